// File: rtl/backlight_frame_sequencer_pkg.sv
// Shared definitions for the backlight frame sequencer.
//   - bl_state_t : sequencer FSM states
//   - GAIN_UNITY : gain of exactly 1.0 in unsigned Q.9
//   - BL_FULL    : full-scale backlight / PWM value
//   - DIVIDEND   : numerator of the reciprocal division (2^19)
package bklight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_COMMIT
  } bl_state_t;

  localparam int GAIN_UNITY = 512;
  localparam int BL_FULL    = 1023;
  localparam int DIVIDEND   = 1 << 19;

endpackage

// File: rtl/backlight_frame_sequencer_if.sv
// Handshake bundle between the sequencer and the external unsigned divider.
//   div_en       : one-cycle start pulse (sequencer -> divider)
//   div_divisor  : divisor, stable from div_en until div_done
//   div_done     : completion strobe (divider -> sequencer)
//   div_quotient : result, valid while div_done is high
// Modports: master = sequencer side, slave = divider side.
interface backlight_frame_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int GAIN_W = 20
) ();
  logic              div_en;
  logic [DATA_W-1:0] div_divisor;
  logic              div_done;
  logic [GAIN_W-1:0] div_quotient;

  modport master (
    output div_en,
    output div_divisor,
    input  div_done,
    input  div_quotient
  );

  modport slave (
    input  div_en,
    input  div_divisor,
    output div_done,
    output div_quotient
  );
endinterface

// File: rtl/backlight_frame_sequencer_frame_max_tracker.sv
// Per-frame peak tracker.
// Detects the vsync rising edge, accumulates the maximum of the three
// linear colour channels over active video, and publishes the peak of the
// completed frame on each edge. Also reports whether any active pixel has
// been seen since the last edge.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   vsync, de           : decoder timing
//   r_lin, g_lin, b_lin : linear pixel channels, sampled when de=1
//   vs_edge             : combinational vsync rising edge
//   frame_max           : peak of the last completed frame
//   seen_de             : an active pixel occurred since the last edge
module frame_max_tracker #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              de,
  input  logic [DATA_W-1:0] r_lin,
  input  logic [DATA_W-1:0] g_lin,
  input  logic [DATA_W-1:0] b_lin,
  output logic              vs_edge,
  output logic [DATA_W-1:0] frame_max,
  output logic              seen_de
);

  logic              vs_q_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] frame_max_reg;
  logic              seen_de_reg;
  logic [DATA_W-1:0] acc_next;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign vs_edge  = vsync & ~vs_q_reg;
  assign acc_next = umax(acc_reg, umax(umax(r_lin, g_lin), b_lin));

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q_reg      <= 1'b0;
      acc_reg       <= '0;
      frame_max_reg <= '0;
      seen_de_reg   <= 1'b0;
    end else begin
      vs_q_reg <= vsync;
      // The frame boundary wins: a pixel coinciding with the edge is dropped.
      if (vs_edge) begin
        acc_reg       <= '0;
        frame_max_reg <= acc_reg;
        seen_de_reg   <= 1'b0;
      end else if (de) begin
        acc_reg     <= acc_next;
        seen_de_reg <= 1'b1;
      end
    end
  end

  assign frame_max = frame_max_reg;
  assign seen_de   = seen_de_reg;

endmodule

// File: rtl/backlight_frame_sequencer.sv
// Backlight frame sequencer.
// On every vsync rising edge derives a backlight level from the previous
// frame's peak, launches one reciprocal division 2^19/level on the external
// divider, and commits the resulting pixel gain (Q.9) together with the PWM
// duty at a frame-safe instant (vertical blanking, or the next edge).
// Optional feature macro: BKLIGHT_SLEW_EN -- when defined the level moves by
// at most MAX_STEP per frame; otherwise it jumps straight to the target.
// Ports:
//   clk, reset          : pixel clock, synchronous active-high reset
//   vsync, de           : decoder timing
//   r_lin, g_lin, b_lin : gamma-linearised channels
//   bypass              : 1 = unity gain, full backlight, sequencer parked
//   div                 : divider handshake (master modport)
//   gain, pwm_value     : committed multiplier coefficient and PWM duty
//   pwm_sync            : one-cycle pulse on each commit
//   frame_max           : peak of the last completed frame
//   busy                : FSM not idle
//   err_timeout         : sticky divider timeout flag
module backlight_frame_sequencer
  import bklight_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int GAIN_W      = 20,
  parameter int MIN_BL      = 64,
  parameter int MAX_STEP    = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vsync,
  input  logic                         de,
  input  logic [DATA_W-1:0]            r_lin,
  input  logic [DATA_W-1:0]            g_lin,
  input  logic [DATA_W-1:0]            b_lin,
  input  logic                         bypass,
  backlight_frame_sequencer_if.master  div,
  output logic [GAIN_W-1:0]            gain,
  output logic [DATA_W-1:0]            pwm_value,
  output logic                         pwm_sync,
  output logic [DATA_W-1:0]            frame_max,
  output logic                         busy,
  output logic                         err_timeout
);

  localparam int TMO_W = $clog2(DIV_TIMEOUT + 1);

`ifdef BKLIGHT_SLEW_EN
  localparam int STEP_LIM = MAX_STEP;
`else
  // The clamp is widened to at least full scale so it can never bind.
  localparam int STEP_LIM = (MAX_STEP < BL_FULL) ? BL_FULL : MAX_STEP;
`endif

  bl_state_t         state_reg;
  logic [GAIN_W-1:0] gain_reg;
  logic [GAIN_W-1:0] pend_gain_reg;
  logic [DATA_W-1:0] pwm_value_reg;
  logic [DATA_W-1:0] prev_bl_reg;
  logic [DATA_W-1:0] divisor_reg;
  logic              div_en_reg;
  logic              pwm_sync_reg;
  logic              restart_reg;
  logic              err_timeout_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;

  logic              vs_edge;
  logic              seen_de;
  logic [DATA_W-1:0] frame_max_int;

  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] level;
  logic [DATA_W:0]   tgt_ext;
  logic [DATA_W:0]   prev_ext;
  logic [DATA_W:0]   delta;

  frame_max_tracker #(.DATA_W(DATA_W)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .de        (de),
    .r_lin     (r_lin),
    .g_lin     (g_lin),
    .b_lin     (b_lin),
    .vs_edge   (vs_edge),
    .frame_max (frame_max_int),
    .seen_de   (seen_de)
  );

  // Level: target floored at MIN_BL (also keeps the divisor non-zero), then
  // approached from prev_bl by at most STEP_LIM. The 1-bit extension keeps
  // the difference from wrapping; prev_bl is always within [MIN_BL, 1023],
  // so stepping never leaves that range either.
  always_comb begin
    target   = (frame_max_int < DATA_W'(MIN_BL)) ? DATA_W'(MIN_BL) : frame_max_int;
    tgt_ext  = {1'b0, target};
    prev_ext = {1'b0, prev_bl_reg};
    level    = target;
    delta    = '0;
    if (tgt_ext > prev_ext) begin
      delta = tgt_ext - prev_ext;
      if (delta > (DATA_W+1)'(STEP_LIM)) begin
        level = prev_bl_reg + DATA_W'(STEP_LIM);
      end
    end else begin
      delta = prev_ext - tgt_ext;
      if (delta > (DATA_W+1)'(STEP_LIM)) begin
        level = prev_bl_reg - DATA_W'(STEP_LIM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      gain_reg        <= GAIN_W'(GAIN_UNITY);
      pend_gain_reg   <= GAIN_W'(GAIN_UNITY);
      pwm_value_reg   <= DATA_W'(BL_FULL);
      prev_bl_reg     <= DATA_W'(BL_FULL);
      divisor_reg     <= DATA_W'(BL_FULL);
      div_en_reg      <= 1'b0;
      pwm_sync_reg    <= 1'b0;
      restart_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      div_en_reg   <= 1'b0;
      pwm_sync_reg <= 1'b0;
      if (bypass) begin
        // Parked: any division in flight is abandoned and its result ignored.
        state_reg     <= ST_IDLE;
        gain_reg      <= GAIN_W'(GAIN_UNITY);
        pwm_value_reg <= DATA_W'(BL_FULL);
        prev_bl_reg   <= DATA_W'(BL_FULL);
        restart_reg   <= 1'b0;
        pwm_sync_reg  <= vs_edge;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (vs_edge || restart_reg) begin
              state_reg   <= ST_CALC;
              restart_reg <= 1'b0;
            end
          end
          ST_CALC: begin
            divisor_reg <= level;
            div_en_reg  <= 1'b1;
            state_reg   <= ST_DIV_START;
            if (vs_edge) restart_reg <= 1'b1;
          end
          ST_DIV_START: begin
            tmo_cnt_reg <= '0;
            state_reg   <= ST_DIV_WAIT;
            if (vs_edge) restart_reg <= 1'b1;
          end
          ST_DIV_WAIT: begin
            if (vs_edge) restart_reg <= 1'b1;
            if (div.div_done) begin
              pend_gain_reg <= div.div_quotient;
              state_reg     <= ST_COMMIT;
            end else if (tmo_cnt_reg == TMO_W'(DIV_TIMEOUT - 1)) begin
              // Give up; outputs and prev_bl keep the last committed values.
              err_timeout_reg <= 1'b1;
              state_reg       <= ST_IDLE;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
          end
          ST_COMMIT: begin
            // Commit only while blanking; once active video has started the
            // new values wait for the next frame boundary.
            if (!seen_de || vs_edge) begin
              gain_reg      <= pend_gain_reg;
              pwm_value_reg <= divisor_reg;
              prev_bl_reg   <= divisor_reg;
              pwm_sync_reg  <= 1'b1;
              state_reg     <= ST_IDLE;
            end
            if (vs_edge) restart_reg <= 1'b1;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign div.div_en      = div_en_reg;
  assign div.div_divisor = divisor_reg;
  assign gain            = gain_reg;
  assign pwm_value       = pwm_value_reg;
  assign pwm_sync        = pwm_sync_reg;
  assign frame_max       = frame_max_int;
  assign busy            = (state_reg != ST_IDLE);
  assign err_timeout     = err_timeout_reg;

endmodule

// File: tb/tb_backlight_frame_sequencer.sv
// Testbench for backlight_frame_sequencer: divider model, scoreboard
// queues for divisor launches and commits, directed frame scenarios.
// Expected values follow BKLIGHT_SLEW_EN when that macro is defined.
`timescale 1ns/1ps
module tb_backlight_frame_sequencer;

  localparam int DATA_W = 10;
  localparam int GAIN_W = 20;

`ifdef BKLIGHT_SLEW_EN
  localparam int EXP_DIV  [9] = '{991, 959, 927, 895, 863, 863, 895, 991, 991};
  localparam int EXP_GAIN [9] = '{529, 546, 565, 585,   0, 607,   0,   0, 529};
`else
  localparam int EXP_DIV  [9] = '{800,   64,  500,  300, 700, 700, 1000, 600, 800};
  localparam int EXP_GAIN [9] = '{655, 8192, 1048, 1747,   0, 748,    0,   0, 655};
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              vsync;
  logic              de;
  logic [DATA_W-1:0] r_lin, g_lin, b_lin;
  logic              bypass;
  logic [GAIN_W-1:0] gain;
  logic [DATA_W-1:0] pwm_value;
  logic              pwm_sync;
  logic [DATA_W-1:0] frame_max;
  logic              busy;
  logic              err_timeout;

  backlight_frame_sequencer_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) div_bus ();

  backlight_frame_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .de          (de),
    .r_lin       (r_lin),
    .g_lin       (g_lin),
    .b_lin       (b_lin),
    .bypass      (bypass),
    .div         (div_bus),
    .gain        (gain),
    .pwm_value   (pwm_value),
    .pwm_sync    (pwm_sync),
    .frame_max   (frame_max),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int sync_count = 0;
  int sync_exp   = 0;
  int div_delay  = 3;
  bit div_drop   = 1'b0;
  int q_div [$];
  int q_gain [$];
  int q_pwm [$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int r, input int g, input int b);
    de = 1'b1;
    r_lin = DATA_W'(r);
    g_lin = DATA_W'(g);
    b_lin = DATA_W'(b);
    tick(1);
    de = 1'b0;
  endtask

  task automatic expect_txn(input int idx, input bit commit);
    q_div.push_back(EXP_DIV[idx]);
    if (commit) begin
      q_gain.push_back(EXP_GAIN[idx]);
      q_pwm.push_back(EXP_DIV[idx]);
      sync_exp++;
    end
  endtask

  task automatic wait_syncs(input string name, input int budget);
    int n = 0;
    while (sync_count < sync_exp && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, sync_count, sync_exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gain"}, int'(gain), 512);
    chk({tag, "_pwm"}, int'(pwm_value), 1023);
    chk({tag, "_divisor"}, int'(div_bus.div_divisor), 1023);
    chk({tag, "_frame_max"}, int'(frame_max), 0);
    chk({tag, "_div_en"}, int'(div_bus.div_en), 0);
    chk({tag, "_pwm_sync"}, int'(pwm_sync), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err_timeout), 0);
  endtask

  // Divider model: answers DIVIDEND/divisor div_delay cycles after div_en.
  initial begin
    int cap;
    div_bus.div_done = 1'b0;
    div_bus.div_quotient = '0;
    forever begin
      @(negedge clk);
      if (div_bus.div_en === 1'b1 && !div_drop) begin
        cap = int'(div_bus.div_divisor);
        repeat (div_delay) @(negedge clk);
        div_bus.div_done = 1'b1;
        div_bus.div_quotient = GAIN_W'(bklight_pkg::DIVIDEND / cap);
        @(negedge clk);
        div_bus.div_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT launches or commits.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (div_bus.div_en === 1'b1) begin
        if (q_div.size() == 0) begin
          chk("div_unexpected", int'(div_bus.div_divisor), -1);
        end else begin
          chk("div_divisor", int'(div_bus.div_divisor), q_div.pop_front());
        end
      end
      if (pwm_sync === 1'b1) begin
        sync_count++;
        $display("commit t=%0t gain=%0d pwm=%0d", $time, gain, pwm_value);
        if (q_gain.size() == 0) begin
          chk("sync_unexpected", int'(gain), -1);
        end else begin
          chk("commit_gain", int'(gain), q_gain.pop_front());
          chk("commit_pwm", int'(pwm_value), q_pwm.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; de = 1'b0; bypass = 1'b0;
    r_lin = '0; g_lin = '0; b_lin = '0;
    tick(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick(2);

    // Frame peak 800, blanking commit, cycle-exact timing.
    pix(100, 200, 800); pix(800, 3, 1); pix(5, 799, 0);
    tick(3);
    expect_txn(0, 1'b1);
    vsync = 1'b1;
    chk("s1_busy_c0", int'(busy), 0);
    tick(1);
    chk("s1_frame_max", int'(frame_max), 800);
    chk("s1_busy_c1", int'(busy), 1);
    tick(1);
    chk("s1_div_en_c2", int'(div_bus.div_en), 1);
    vsync = 1'b0;
    tick(4);
    chk("s1_sync_c6", int'(pwm_sync), 0);
    tick(1);
    chk("s1_sync_c7", int'(pwm_sync), 1);
    chk("s1_gain", int'(gain), EXP_GAIN[0]);
    chk("s1_pwm", int'(pwm_value), EXP_DIV[0]);
    wait_syncs("s1_sync_wait", 20);

    // Black frame; a pixel coinciding with the edge must be dropped.
    pix(0, 0, 0); pix(0, 0, 0);
    tick(2);
    expect_txn(1, 1'b1);
    de = 1'b1; r_lin = 10'd1000; vsync = 1'b1;
    tick(1);
    de = 1'b0; r_lin = '0;
    chk("s2_frame_max", int'(frame_max), 0);
    tick(2);
    vsync = 1'b0;
    wait_syncs("s2_sync_wait", 40);

    // Slow divider: active video starts before done, commit deferred to edge.
    div_delay = 20;
    pix(500, 10, 10); pix(0, 499, 0);
    tick(2);
    expect_txn(2, 1'b1);
    vsync = 1'b1;
    tick(1);
    chk("s3_frame_max", int'(frame_max), 500);
    tick(2);
    vsync = 1'b0;
    tick(4);
    for (int i = 0; i < 50; i++) begin
      pix(300, 12, 299);
      if (i == 30) begin
        chk("s3_hold_busy", int'(busy), 1);
        chk("s3_hold_gain", int'(gain), EXP_GAIN[1]);
        chk("s3_hold_syncs", sync_count, sync_exp - 1);
      end
    end
    tick(3);
    div_delay = 3;
    expect_txn(3, 1'b1);
    vsync = 1'b1;
    tick(1);
    chk("s3_edge_sync", int'(pwm_sync), 1);
    chk("s3_edge_gain", int'(gain), EXP_GAIN[2]);
    chk("s3_edge_pwm", int'(pwm_value), EXP_DIV[2]);
    chk("s3_frame_max2", int'(frame_max), 300);
    tick(1);
    chk("s3_restart_busy", int'(busy), 1);
    tick(1);
    vsync = 1'b0;
    wait_syncs("s3_sync_wait", 40);

    // Divider never answers: timeout, outputs held, next frame normal.
    div_drop = 1'b1;
    pix(700, 0, 0);
    tick(2);
    expect_txn(4, 1'b0);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(57);
    chk("s4_err_early", int'(err_timeout), 0);
    chk("s4_busy_wait", int'(busy), 1);
    tick(10);
    chk("s4_err_set", int'(err_timeout), 1);
    chk("s4_busy_idle", int'(busy), 0);
    chk("s4_gain_held", int'(gain), EXP_GAIN[3]);
    chk("s4_pwm_held", int'(pwm_value), EXP_DIV[3]);
    div_drop = 1'b0;
    pix(0, 700, 0);
    tick(2);
    expect_txn(5, 1'b1);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    wait_syncs("s4_sync_wait", 40);
    chk("s4_err_sticky", int'(err_timeout), 1);

    // Bypass raised during DIV_WAIT; late done ignored; sync on bypassed edge.
    div_delay = 10;
    pix(1000, 0, 0);
    tick(2);
    expect_txn(6, 1'b0);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(2);
    bypass = 1'b1;
    tick(1);
    chk("s5_gain", int'(gain), 512);
    chk("s5_pwm", int'(pwm_value), 1023);
    chk("s5_busy", int'(busy), 0);
    tick(10);
    chk("s5_late_gain", int'(gain), 512);
    chk("s5_late_busy", int'(busy), 0);
    chk("s5_late_syncs", sync_count, sync_exp);
    pix(0, 0, 321);
    tick(2);
    q_gain.push_back(512); q_pwm.push_back(1023); sync_exp++;
    vsync = 1'b1;
    tick(1);
    chk("s5_byp_sync", int'(pwm_sync), 1);
    chk("s5_byp_frame_max", int'(frame_max), 321);
    chk("s5_byp_busy", int'(busy), 0);
    tick(2);
    vsync = 1'b0;
    tick(2);
    bypass = 1'b0;

    // Reset during DIV_WAIT.
    div_delay = 15;
    pix(600, 600, 0);
    tick(2);
    expect_txn(7, 1'b0);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("s6");
    reset = 1'b0;
    tick(15);
    chk("s6_late_busy", int'(busy), 0);
    chk("s6_late_gain", int'(gain), 512);
    chk("s6_late_syncs", sync_count, sync_exp);

    // Recovery frame after reset.
    div_delay = 3;
    pix(800, 0, 0);
    tick(2);
    expect_txn(8, 1'b1);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    wait_syncs("s7_sync_wait", 40);

    tick(5);
    chk("end_div_queue", q_div.size(), 0);
    chk("end_commit_queue", q_gain.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
